// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_DIV  = 2'd1,
    RUN_MULT = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_MULT = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 65535;
  localparam int unsigned DEFAULT_CNT_W          = 32;

endpackage

// File: rtl/muldiv_watchdog.sv
// Run-cycle counter for the sequencer; flags expiry when the operation overstays.
module muldiv_watchdog
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = count_reg + ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Fires on the edge that would bring the count up to the limit.
  assign expire = (TIMEOUT_CYCLES != 0) && enable && !clear && (count_next == LIMIT);

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer that launches the divider or multiplier, waits for Done and
// commits the result into HI/LO, with divide-by-zero and watchdog flags.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Start,
  input  logic        Op,
  input  logic [31:0] RegAOut,
  input  logic [31:0] RegBOut,
  output logic [31:0] OpAOut,
  output logic [31:0] OpBOut,
  output logic        DivCtrl,
  input  logic        DivDone,
  input  logic        Div0,
  input  logic [31:0] DivHIIn,
  input  logic [31:0] DivLOIn,
  output logic        MultCtrl,
  input  logic        MultDone,
  input  logic [31:0] MultHIIn,
  input  logic [31:0] MultLOIn,
  output logic        Busy,
  output logic        Done,
  output logic        Div0Exc,
  output logic        Timeout,
  output logic [31:0] HIOut,
  output logic [31:0] LOOut
);

  state_t      state_reg;
  logic [31:0] opa_reg;
  logic [31:0] opb_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        div_ctrl_reg;
  logic        mult_ctrl_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        div0_exc_reg;
  logic        timeout_reg;

  logic accept;
  logic wd_enable;
  logic wd_expire;

  assign accept    = (state_reg == IDLE) && Start;
  assign wd_enable = (state_reg == RUN_DIV) || (state_reg == RUN_MULT);

  muldiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .enable(wd_enable),
    .expire(wd_expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      opa_reg       <= '0;
      opb_reg       <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      div_ctrl_reg  <= 1'b0;
      mult_ctrl_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      div0_exc_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            opa_reg      <= RegAOut;
            opb_reg      <= RegBOut;
            div0_exc_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            busy_reg     <= 1'b1;
            case (Op)
              OP_DIV:  state_reg <= RUN_DIV;
              OP_MULT: state_reg <= RUN_MULT;
            endcase
          end
        end
        RUN_DIV: begin
          // Ctrl rises one cycle after the operands were latched.
          div_ctrl_reg <= 1'b1;
          if (div_ctrl_reg && DivDone) begin
            div_ctrl_reg <= 1'b0;
            done_reg     <= 1'b1;
            state_reg    <= RELEASE;
            if (Div0) begin
              div0_exc_reg <= 1'b1;
            end else begin
              lo_reg <= DivHIIn;
              hi_reg <= DivLOIn;
            end
          end else if (wd_expire) begin
            div_ctrl_reg <= 1'b0;
            timeout_reg  <= 1'b1;
            done_reg     <= 1'b1;
            state_reg    <= RELEASE;
          end
        end
        RUN_MULT: begin
          mult_ctrl_reg <= 1'b1;
          if (mult_ctrl_reg && MultDone) begin
            mult_ctrl_reg <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= RELEASE;
            hi_reg        <= MultHIIn;
            lo_reg        <= MultLOIn;
          end else if (wd_expire) begin
            mult_ctrl_reg <= 1'b0;
            timeout_reg   <= 1'b1;
            done_reg      <= 1'b1;
            state_reg     <= RELEASE;
          end
        end
        RELEASE: begin
          // Ctrl is already low here, giving the unit one cycle to re-arm.
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign OpAOut   = opa_reg;
  assign OpBOut   = opb_reg;
  assign DivCtrl  = div_ctrl_reg;
  assign MultCtrl = mult_ctrl_reg;
  assign Busy     = busy_reg;
  assign Done     = done_reg;
  assign Div0Exc  = div0_exc_reg;
  assign Timeout  = timeout_reg;
  assign HIOut    = hi_reg;
  assign LOOut    = lo_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: two instances (default and 16-cycle watchdog) driving
// latency-programmable mock divider/multiplier units.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        start[2];
  logic        op[2];
  logic [31:0] rega[2];
  logic [31:0] regb[2];
  logic [31:0] opa[2];
  logic [31:0] opb[2];
  logic        div_ctrl[2];
  logic        div_done[2];
  logic        div0[2];
  logic [31:0] div_q[2];
  logic [31:0] div_r[2];
  logic        mult_ctrl[2];
  logic        mult_done[2];
  logic        busy[2];
  logic        done[2];
  logic        div0_exc[2];
  logic        tmo[2];
  logic [31:0] hi[2];
  logic [31:0] lo[2];

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          div_lat[2];
  int          mult_lat;

  logic [31:0] mdl_hi[2];
  logic [31:0] mdl_lo[2];

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b, input bit rem);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return 32'hDEADBEEF;
    r = rem ? (sa % sb) : (sa / sb);
    return r[31:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      int dcnt;
      int mcnt;

      muldiv_seq #(
        .TIMEOUT_CYCLES(gi == 0 ? 65535 : 16),
        .CNT_W         (32)
      ) u_dut (
        .clock   (clock),
        .reset   (reset),
        .Start   (start[gi]),
        .Op      (op[gi]),
        .RegAOut (rega[gi]),
        .RegBOut (regb[gi]),
        .OpAOut  (opa[gi]),
        .OpBOut  (opb[gi]),
        .DivCtrl (div_ctrl[gi]),
        .DivDone (div_done[gi]),
        .Div0    (div0[gi]),
        .DivHIIn (div_q[gi]),
        .DivLOIn (div_r[gi]),
        .MultCtrl(mult_ctrl[gi]),
        .MultDone(mult_done[gi]),
        .MultHIIn(m_hi),
        .MultLOIn(m_lo),
        .Busy    (busy[gi]),
        .Done    (done[gi]),
        .Div0Exc (div0_exc[gi]),
        .Timeout (tmo[gi]),
        .HIOut   (hi[gi]),
        .LOOut   (lo[gi])
      );

      // Mock units: Done rises in the lat-th cycle of Ctrl high, held until Ctrl drops.
      always @(posedge clock or negedge reset) begin
        if (!reset) begin
          dcnt <= 0;
          mcnt <= 0;
        end else begin
          dcnt <= div_ctrl[gi] ? dcnt + 1 : 0;
          mcnt <= mult_ctrl[gi] ? mcnt + 1 : 0;
        end
      end
      assign div_done[gi]  = div_ctrl[gi] && (dcnt >= div_lat[gi] - 1);
      assign mult_done[gi] = mult_ctrl[gi] && (mcnt >= mult_lat - 1);
      assign div0[gi]      = (opb[gi] == 32'd0);
      assign div_q[gi]     = sdiv(opa[gi], opb[gi], 1'b0);
      assign div_r[gi]     = sdiv(opa[gi], opb[gi], 1'b1);
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // One operation on instance d; expectations come from the sequencer rules.
  task automatic do_op(input int d, input logic o, input logic [31:0] a, input logic [31:0] b,
                       input bit spam, input string tag, output int busy_out);
    int lat, lim, busy_cyc, ctrl_cyc, other_cyc, done_cnt, guard;
    bit exp_tmo, exp_div0;
    logic [31:0] exp_hi, exp_lo;
    lim      = (d == 0) ? 65535 : 16;
    lat      = (o == OP_MULT) ? mult_lat : div_lat[d];
    exp_tmo  = (lim != 0) && (lat + 1 > lim);
    exp_div0 = !exp_tmo && (o == OP_DIV) && (b == 32'd0);
    exp_hi   = mdl_hi[d];
    exp_lo   = mdl_lo[d];
    if (!exp_tmo && !exp_div0) begin
      if (o == OP_MULT) begin
        exp_hi = m_hi;
        exp_lo = m_lo;
      end else begin
        exp_lo = sdiv(a, b, 1'b0);
        exp_hi = sdiv(a, b, 1'b1);
      end
    end
    @(negedge clock);
    start[d] = 1'b1; op[d] = o; rega[d] = a; regb[d] = b;
    @(negedge clock);
    start[d] = spam; rega[d] = $urandom; regb[d] = $urandom;
    busy_cyc = 0; ctrl_cyc = 0; other_cyc = 0; done_cnt = 0; guard = 0;
    while (busy[d] === 1'b1 && guard < 300) begin
      busy_cyc++;
      if (done[d] === 1'b1) done_cnt++;
      if (o == OP_MULT) begin
        if (mult_ctrl[d] === 1'b1) ctrl_cyc++;
        if (div_ctrl[d] !== 1'b0) other_cyc++;
      end else begin
        if (div_ctrl[d] === 1'b1) ctrl_cyc++;
        if (mult_ctrl[d] !== 1'b0) other_cyc++;
      end
      guard++;
      @(negedge clock);
    end
    start[d] = 1'b0;
    busy_out = busy_cyc;
    check({tag, ".bound"}, 32'(guard < 300), 32'd1);
    check({tag, ".busy_cycles"}, busy_cyc, exp_tmo ? lim + 1 : lat + 2);
    check({tag, ".ctrl_cycles"}, ctrl_cyc, exp_tmo ? lim - 1 : lat);
    check({tag, ".other_ctrl"}, other_cyc, 0);
    check({tag, ".done_pulses"}, done_cnt, 1);
    check({tag, ".done_after"}, done[d], 1'b0);
    check({tag, ".hi"}, hi[d], exp_hi);
    check({tag, ".lo"}, lo[d], exp_lo);
    check({tag, ".div0exc"}, div0_exc[d], exp_div0);
    check({tag, ".timeout"}, tmo[d], exp_tmo);
    check({tag, ".opa"}, opa[d], a);
    check({tag, ".opb"}, opb[d], b);
    mdl_hi[d] = exp_hi;
    mdl_lo[d] = exp_lo;
    $display("[TB] %s dev=%0d op=%0d a=%h b=%h -> hi=%h lo=%h div0=%0d tmo=%0d busy=%0d",
             tag, d, o, a, b, hi[d], lo[d], div0_exc[d], tmo[d], busy_cyc);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int bc;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; op[d] = 1'b0; rega[d] = '0; regb[d] = '0;
      mdl_hi[d] = '0; mdl_lo[d] = '0; div_lat[d] = 33;
    end
    m_hi = '0; m_lo = '0; mult_lat = 33;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset%0d.busy", d), busy[d], 1'b0);
      check($sformatf("reset%0d.done", d), done[d], 1'b0);
      check($sformatf("reset%0d.ctrl", d), {div_ctrl[d], mult_ctrl[d]}, 2'b00);
      check($sformatf("reset%0d.flags", d), {div0_exc[d], tmo[d]}, 2'b00);
      check($sformatf("reset%0d.hi", d), hi[d], 32'd0);
      check($sformatf("reset%0d.lo", d), lo[d], 32'd0);
      check($sformatf("reset%0d.opa", d), opa[d], 32'd0);
      check($sformatf("reset%0d.opb", d), opb[d], 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);

    // MULT with 33-cycle unit: Busy must span 35 cycles.
    mult_lat = 33; m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFA;
    do_op(0, OP_MULT, 32'd2, 32'hFFFFFFFD, 1'b0, "mult33", bc);
    check("mult33.busy35", bc, 35);
    check("mult33.hi_const", hi[0], 32'hFFFFFFFF);
    check("mult33.lo_const", lo[0], 32'hFFFFFFFA);

    // Signed divide 7 / -3.
    div_lat[0] = 33;
    do_op(0, OP_DIV, 32'd7, 32'hFFFFFFFD, 1'b0, "div7_m3", bc);
    check("div7_m3.lo_const", lo[0], 32'hFFFFFFFE);
    check("div7_m3.hi_const", hi[0], 32'd1);

    // Divide by zero leaves HI/LO from the preceding MULT.
    m_hi = 32'h12; m_lo = 32'h34; mult_lat = 10;
    do_op(0, OP_MULT, 32'd3, 32'd4, 1'b0, "mult_12_34", bc);
    do_op(0, OP_DIV, 32'd5, 32'd0, 1'b0, "div_by0", bc);
    check("div_by0.exc_const", div0_exc[0], 1'b1);
    check("div_by0.hi_const", hi[0], 32'h12);
    check("div_by0.lo_const", lo[0], 32'h34);

    // Start held every cycle during a DIV.
    do_op(0, OP_DIV, 32'd1000, 32'd3, 1'b1, "spam", bc);
    check("spam.opa_const", opa[0], 32'd1000);

    // Watchdog instance: timeout, re-arm, then Done/timeout coincidence.
    div_lat[1] = 40;
    do_op(1, OP_DIV, 32'h7FFFFFFF, 32'd1, 1'b0, "wd_timeout", bc);
    check("wd_timeout.flag_const", tmo[1], 1'b1);
    check("wd_timeout.busy17", bc, 17);
    div_lat[1] = 5;
    do_op(1, OP_DIV, 32'd9, 32'd2, 1'b0, "wd_rearm", bc);
    check("wd_rearm.lo_const", lo[1], 32'd4);
    check("wd_rearm.hi_const", hi[1], 32'd1);
    div_lat[1] = 15;
    do_op(1, OP_DIV, 32'd20, 32'd3, 1'b0, "wd_tie", bc);
    check("wd_tie.flag_const", tmo[1], 1'b0);
    check("wd_tie.lo_const", lo[1], 32'd6);

    // Randomized operations against the model.
    for (int i = 0; i < 24; i++) begin
      int          d;
      logic        o;
      logic [31:0] a, b;
      d = int'($urandom_range(1, 0));
      o = 1'($urandom_range(1, 0));
      a = $urandom;
      b = ($urandom_range(4, 0) == 0) ? 32'd0 : $urandom;
      m_hi = $urandom; m_lo = $urandom;
      if (d == 0) begin
        div_lat[0] = int'($urandom_range(40, 1));
        mult_lat   = int'($urandom_range(40, 1));
      end else begin
        div_lat[1] = int'($urandom_range(20, 1));
        mult_lat   = int'($urandom_range(20, 1));
      end
      do_op(d, o, a, b, 1'($urandom_range(1, 0)), $sformatf("rnd%0d", i), bc);
    end

    // Asynchronous reset in the middle of a DIV.
    div_lat[0] = 33;
    @(negedge clock);
    start[0] = 1'b1; op[0] = OP_DIV; rega[0] = 32'hCAFE0001; regb[0] = 32'd3;
    @(negedge clock);
    start[0] = 1'b0;
    repeat (5) @(negedge clock);
    check("arst.pre_ctrl", div_ctrl[0], 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst.ctrl", div_ctrl[0], 1'b0);
    check("arst.busy", busy[0], 1'b0);
    check("arst.hi", hi[0], 32'd0);
    check("arst.lo", lo[0], 32'd0);
    check("arst.opa", opa[0], 32'd0);
    $display("[TB] async reset mid-DIV: ctrl=%0d busy=%0d hi=%h lo=%h", div_ctrl[0], busy[0], hi[0], lo[0]);
    for (int d = 0; d < 2; d++) begin
      mdl_hi[d] = '0; mdl_lo[d] = '0;
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_op(0, OP_DIV, 32'd100, 32'd7, 1'b0, "post_rst", bc);
    check("post_rst.lo_const", lo[0], 32'd14);
    check("post_rst.hi_const", hi[0], 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequencer between the CPU control unit and the two iterative arithmetic units: the signed divider and the multiplier.
- Latches operands and starts the selected unit using its level-held Ctrl handshake.
- Waits for the unit's Done, commits the result into the architectural HI/LO registers, then releases the unit so it re-arms.
- Stalls the control unit while busy; flags divide-by-zero and a watchdog timeout.

Parameters:
- TIMEOUT_CYCLES, 65535: maximum number of RUN cycles before the operation is aborted; 0 disables the watchdog.
- CNT_W, 32: width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle request from the control unit
- Op  in  1  operation select: 0 = DIV, 1 = MULT
- RegAOut  in  32  operand A, sampled on Start
- RegBOut  in  32  operand B, sampled on Start
- OpAOut  out  32  latched operand A to both units
- OpBOut  out  32  latched operand B to both units
- DivCtrl  out  1  divider run level
- DivDone  in  1  divider finished
- Div0  in  1  divider zero-divisor flag
- DivHIIn  in  32  divider quotient
- DivLOIn  in  32  divider remainder
- MultCtrl  out  1  multiplier run level
- MultDone  in  1  multiplier finished
- MultHIIn  in  32  product high word
- MultLOIn  in  32  product low word
- Busy  out  1  stall to control unit
- Done  out  1  one-cycle completion pulse
- Div0Exc  out  1  sticky divide-by-zero flag; cleared by next accepted Start
- Timeout  out  1  sticky watchdog flag; cleared by next accepted Start
- HIOut  out  32  architectural HI
- LOOut  out  32  architectural LO

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - All outputs and registers are 0: OpAOut, OpBOut, DivCtrl, MultCtrl, Busy, Done, Div0Exc, Timeout, HIOut, LOOut, watchdog counter.
- All outputs are registered.
- States:
  - IDLE → RUN_DIV / RUN_MULT → RELEASE → IDLE.
- IDLE:
  - Busy = 0, both Ctrl = 0.
  - On Start = 1: latch RegAOut/RegBOut into OpAOut/OpBOut, record Op, clear Div0Exc and Timeout, clear counter, set Busy = 1.
  - Next state is RUN_DIV (Op = 0) or RUN_MULT (Op = 1).
  - Operands are therefore stable for at least one cycle before Ctrl rises.
- RUN_x:
  - Assert that unit's Ctrl; the other unit's Ctrl stays 0; increment the counter each cycle.
  - Ctrl rises in the cycle after Start is accepted.
  - On the edge where the unit's Done = 1, results are valid. Go to RELEASE with:
    - DIV with Div0 = 1: HI/LO unchanged, Div0Exc = 1.
    - DIV otherwise: LOOut = DivHIIn (quotient), HIOut = DivLOIn (remainder), i.e. MIPS convention.
    - MULT: HIOut = MultHIIn, LOOut = MultLOIn.
  - Watchdog: if TIMEOUT_CYCLES ≠ 0 and counter reaches TIMEOUT_CYCLES without Done, set Timeout = 1, leave HI/LO unchanged, go to RELEASE.
  - If Done and the timeout coincide on the same edge, Done wins: commit the result, Timeout stays 0.
- RELEASE:
  - Both Ctrl = 0 for exactly one cycle; this lets the unit re-arm.
  - Done = 1 for this single cycle; Busy = 0 in the following cycle.
  - Next state is IDLE.
- Start while Busy = 1, including during RELEASE, is ignored with no queuing.
- Latency: Start accepted at edge n; Ctrl high from n+1; Done pulse one cycle after unit Done is sampled. Total = unit cycles + 2.
- Asynchronous reset mid-operation:
  - Ctrl drops immediately and HI/LO clear.
  - The arithmetic unit re-arms because it sees its Ctrl low.
- HI/LO are written only on a successful commit.

Decomposition:
- Package muldiv_pkg:
  - State encoding constants: IDLE = 2'd0, RUN_DIV = 2'd1, RUN_MULT = 2'd2, RELEASE = 2'd3.
  - Op codes OP_DIV = 1'b0, OP_MULT = 1'b1.
  - Default TIMEOUT_CYCLES.
- One sub-module: muldiv_watchdog, containing the counter, compare and clear/enable logic.
- The FSM and HI/LO registers live in the top.

Test Plan:
- DIV A = 7, B = 0xFFFFFFFD (−3), with the real divider → Done pulse; LOOut = 0xFFFFFFFE (−2), HIOut = 1; Div0Exc = 0; DivCtrl low exactly one cycle before IDLE.
- DIV A = 5, B = 0 after a prior MULT that left HI = 0x12, LO = 0x34 → Div0Exc = 1; HIOut/LOOut stay 0x12/0x34; Done pulses.
- MULT with a mock multiplier asserting MultDone after 33 cycles, returning HI = 0xFFFFFFFF, LO = 0xFFFFFFFA → values committed; Busy high for 35 cycles.
- TIMEOUT_CYCLES = 16; DIV 0x7FFFFFFF / 1 → Timeout = 1 after 16 RUN cycles; DivCtrl drops; HI/LO unchanged. A following DIV 9/2 then gives LO = 4, HI = 1, proving the divider re-armed.
- Start pulsed every cycle during a DIV → only the first is accepted; exactly one Done pulse; OpAOut unchanged.
- reset driven low mid-RUN_DIV, asynchronous to the clock → outputs 0 before the next edge. After release, DIV 100/7 → LO = 14, HI = 2.
